// File: rtl/debug_jtag_host_pkg.sv
// Shared defaults and FSM state encoding for the virtual JTAG host shifter.
package debug_jtag_host_pkg;

  localparam int unsigned SR_WIDTH_DEF = 38;
  localparam int unsigned IR_WIDTH_DEF = 2;
  localparam int unsigned TCK_DIV_DEF  = 2;

  // State encoding of the host FSM; ST_RTI is only reachable with the RTI phase built in.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_UIR   = 3'd1;
  localparam logic [2:0] ST_CDR   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_UDR   = 3'd4;
  localparam logic [2:0] ST_RTI   = 3'd5;
  localparam logic [2:0] ST_RESP  = 3'd6;

endpackage

// File: rtl/debug_jtag_host_tckgen.sv
// TCK divider: each TCK period is TCK_DIV clk cycles low followed by TCK_DIV cycles high.
module debug_jtag_host_tckgen
  import debug_jtag_host_pkg::*;
#(
  parameter int unsigned TCK_DIV = TCK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam logic [8:0] HALF_LAST = 9'(TCK_DIV - 1);
  localparam logic [8:0] FULL_LAST = 9'(2 * TCK_DIV - 1);

  logic [8:0] cnt;

  // Strobes mark the clk cycle whose closing edge raises / lowers tck.
  assign tck_rise = enable && (cnt == HALF_LAST);
  assign tck_fall = enable && (cnt == FULL_LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= tck_fall ? '0 : cnt + 9'd1;
      if (tck_rise)
        tck <= 1'b1;
      else if (tck_fall)
        tck <= 1'b0;
    end
  end

endmodule

// File: rtl/debug_jtag_host_shifter.sv
// Host-side virtual JTAG shifter: per command runs UIR, CDR, SHIFT, UDR and returns captured TDO bits.
// Define DEBUG_JTAG_HOST_RTI_EN to append a one-TCK Run-Test/Idle phase after UDR.
module debug_jtag_host_shifter
  import debug_jtag_host_pkg::*;
#(
  parameter int unsigned SR_WIDTH = SR_WIDTH_DEF,
  parameter int unsigned IR_WIDTH = IR_WIDTH_DEF,
  parameter int unsigned TCK_DIV  = TCK_DIV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_uir,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam logic [6:0] LAST_BIT = 7'(SR_WIDTH - 1);

  logic [2:0]          state;
  logic [SR_WIDTH-1:0] sr;
  logic [6:0]          bit_cnt;
  logic                tck_en;
  logic                tck_rise;
  logic                tck_fall;

  assign cmd_ready = !reset && (state == ST_IDLE) && !rsp_valid;
  assign tck_en    = (state != ST_IDLE) && (state != ST_RESP);
  assign vji_uir   = (state == ST_UIR);
  assign vji_cdr   = (state == ST_CDR);
  assign vji_sdr   = (state == ST_SHIFT);
  assign vji_udr   = (state == ST_UDR);
`ifdef DEBUG_JTAG_HOST_RTI_EN
  assign vji_rti   = (state == ST_RTI);
`else
  assign vji_rti   = 1'b0;
`endif

  debug_jtag_host_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk      (clk),
    .reset    (reset),
    .enable   (tck_en),
    .tck      (vji_tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            vji_ir_in <= cmd_ir;
            sr        <= cmd_data;
            bit_cnt   <= '0;
            state     <= ST_UIR;
          end
        end
        ST_UIR: begin
          if (tck_rise)
            rsp_ir_out <= vji_ir_out;
          if (tck_fall)
            state <= ST_CDR;
        end
        ST_CDR: begin
          if (tck_fall) begin
            state   <= ST_SHIFT;
            vji_tdi <= sr[0];
          end
        end
        ST_SHIFT: begin
          // Capture on the TCK rise; present the next TDI bit on the following fall.
          if (tck_rise)
            sr <= {vji_tdo, sr[SR_WIDTH-1:1]};
          if (tck_fall) begin
            if (bit_cnt == LAST_BIT) begin
              state   <= ST_UDR;
              vji_tdi <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 7'd1;
              vji_tdi <= sr[0];
            end
          end
        end
        ST_UDR: begin
          if (tck_fall) begin
`ifdef DEBUG_JTAG_HOST_RTI_EN
            state <= ST_RTI;
`else
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
`endif
          end
        end
`ifdef DEBUG_JTAG_HOST_RTI_EN
        ST_RTI: begin
          if (tck_fall) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= sr;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_jtag_host_shifter.sv
// Self-checking bench: cycle-offset reference model for the default build plus directed cases.
module tb_debug_jtag_host_shifter;

`ifdef DEBUG_JTAG_HOST_RTI_EN
  localparam int RTI = 1;
`else
  localparam int RTI = 0;
`endif
  localparam int SR = 38;
  localparam int TD = 2;
  localparam int PER = 2 * TD;
  localparam int ACT = (SR + 3 + RTI) * PER;
  localparam int LAT_MAIN = (RTI == 1) ? 169 : 165;
  localparam int LAT_SMALL = (RTI == 1) ? 13 : 11;
  localparam int ACT_SMALL = (2 + 3 + RTI) * 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0, cmd_ready;
  logic [1:0]    cmd_ir = '0;
  logic [SR-1:0] cmd_data = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [SR-1:0] rsp_data;
  logic [1:0]    rsp_ir_out, vji_ir_in;
  logic [1:0]    vji_ir_out = '0;
  logic          vji_tck, vji_tdi, vji_cdr, vji_sdr, vji_udr, vji_uir, vji_rti, vji_tdo;

  debug_jtag_host_shifter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .vji_tck(vji_tck), .vji_tdi(vji_tdi),
    .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_uir(vji_uir),
    .vji_rti(vji_rti), .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out)
  );

  // Slave: one-bit TDI->TDO delay line, cleared in Capture-DR.
  logic slave_bit = 1'b0;
  always @(posedge vji_tck or posedge vji_cdr)
    if (vji_cdr) slave_bit <= 1'b0;
    else if (vji_sdr) slave_bit <= vji_tdi;
  assign vji_tdo = slave_bit;

  // Small configuration: SR_WIDTH=2, TCK_DIV=1, TDO held high.
  logic       s_cmd_valid = 1'b0, s_cmd_ready, s_rsp_valid, s_rsp_ready = 1'b1;
  logic [1:0] s_cmd_ir = '0, s_cmd_data = '0, s_rsp_data, s_rsp_ir_out, s_vji_ir_in;
  logic [1:0] s_vji_ir_out = '0;
  logic       s_tck, s_tdi, s_cdr, s_sdr, s_udr, s_uir, s_rti;
  logic       s_tdo = 1'b1;

  debug_jtag_host_shifter #(.SR_WIDTH(2), .IR_WIDTH(2), .TCK_DIV(1)) dut_small (
    .clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_ir(s_cmd_ir), .cmd_data(s_cmd_data), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_data(s_rsp_data), .rsp_ir_out(s_rsp_ir_out), .vji_tck(s_tck), .vji_tdi(s_tdi),
    .vji_cdr(s_cdr), .vji_sdr(s_sdr), .vji_udr(s_udr), .vji_uir(s_uir),
    .vji_rti(s_rti), .vji_ir_in(s_vji_ir_in), .vji_tdo(s_tdo), .vji_ir_out(s_vji_ir_out)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int dcyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dcyc++;
  endtask

  // Reference model: outputs derived from the cycle offset since the accept cycle.
  bit            armed = 0, busy = 0, m_rspv = 0;
  int            acc = 0, k = 0, p = 0, ph = 0;
  logic [SR-1:0] m_cmd = '0, m_cap = '0, m_rsp = '0;
  logic [1:0]    m_irin = '0, m_irout = '0;
  logic          e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti, e_ready;

  always @(negedge clk) begin
    cyc++;
    if (!armed) begin
      if (reset) armed = 1;
    end else begin
      k = busy ? cyc - acc - 1 : -1;
      if (busy && k == ACT) begin
        busy = 0;
        m_rspv = 1;
        m_rsp = m_cap;
      end
      {e_tck, e_tdi, e_uir, e_cdr, e_sdr, e_udr, e_rti} = '0;
      p = 0; ph = 0;
      if (busy) begin
        p = k / PER;
        ph = k % PER;
        e_tck = (ph >= TD);
        e_uir = (p == 0);
        e_cdr = (p == 1);
        e_sdr = (p >= 2) && (p < SR + 2);
        e_udr = (p == SR + 2);
        e_rti = (RTI == 1) && (p == SR + 3);
        if (e_sdr) e_tdi = m_cmd[p-2];
      end
      e_ready = !reset && !busy && !m_rspv;
      chk("cmd_ready", 64'(cmd_ready), 64'(e_ready));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
      chk("rsp_data", 64'(rsp_data), 64'(m_rsp));
      chk("rsp_ir_out", 64'(rsp_ir_out), 64'(m_irout));
      chk("vji_ir_in", 64'(vji_ir_in), 64'(m_irin));
      chk("vji_tck", 64'(vji_tck), 64'(e_tck));
      chk("vji_tdi", 64'(vji_tdi), 64'(e_tdi));
      chk("vji_uir", 64'(vji_uir), 64'(e_uir));
      chk("vji_cdr", 64'(vji_cdr), 64'(e_cdr));
      chk("vji_sdr", 64'(vji_sdr), 64'(e_sdr));
      chk("vji_udr", 64'(vji_udr), 64'(e_udr));
      chk("vji_rti", 64'(vji_rti), 64'(e_rti));
      if (reset) begin
        busy = 0; m_rspv = 0; m_rsp = '0; m_irout = '0; m_irin = '0;
      end else begin
        if (busy && p == 0 && ph == TD - 1) m_irout = vji_ir_out;
        if (busy && e_sdr && ph == TD - 1) m_cap[p-2] = vji_tdo;
        if (m_rspv && rsp_ready) m_rspv = 0;
        else if (e_ready && cmd_valid) begin
          busy = 1; acc = cyc; m_cmd = cmd_data; m_irin = cmd_ir; m_cap = '0;
        end
      end
    end
  end

  // Directed command on the default DUT; optional busy pulse or reset at loop index.
  task automatic run_cmd(input logic [1:0] ir, input logic [SR-1:0] data, input int pulse_at,
                         input int reset_at, output int lat, output int rises);
    int a, n;
    logic tprev;
    lat = -1; rises = 0; n = 0;
    cmd_ir = ir; cmd_data = data;
    while (!cmd_ready && n < 300) begin tick(); n++; end
    if (!cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: cmd_ready stayed 0, required 1");
      return;
    end
    cmd_valid = 1'b1; a = dcyc;
    tick();
    cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~data;
    tprev = 1'b0;
    for (int i = 1; i < 400; i++) begin
      if (vji_tck && !tprev && vji_sdr) rises++;
      tprev = vji_tck;
      if (rsp_valid) begin lat = dcyc - a; return; end
      cmd_valid = (i == pulse_at);
      if (i == pulse_at) chk("busy_cmd_ready", 64'(cmd_ready), 64'd0);
      if (i == reset_at) begin
        chk("in_shift_before_reset", 64'(vji_sdr), 64'd1);
        reset = 1'b1;
        tick();
        return;
      end
      tick();
    end
    n_chk++; n_fail++;
    $display("FAIL rsp_timeout: rsp_valid stayed 0, required 1");
  endtask

  int lat, rises, edges, tck_err;
  logic tprev;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    // Loopback command with a busy pulse mid-SHIFT and a long response stall.
    vji_ir_out = 2'b10;
    run_cmd(2'b01, 38'h2A_5555_5555, 40, -1, lat, rises);
    chk("latency_main", 64'(lat), 64'(LAT_MAIN));
    chk("sdr_rises", 64'(rises), 64'd38);
    chk("ir_in_literal", 64'(vji_ir_in), 64'h1);
    chk("rsp_data_literal", 64'(rsp_data), 64'h14_AAAA_AAAA);
    chk("rsp_ir_out_literal", 64'(rsp_ir_out), 64'h2);
    edges = 0; tprev = vji_tck;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (vji_tck != tprev) edges++;
      tprev = vji_tck;
    end
    chk("stall_tck_edges", 64'(edges), 64'd0);
    chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("stall_rsp_data", 64'(rsp_data), 64'h14_AAAA_AAAA);
    chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("handshake_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("handshake_cmd_ready", 64'(cmd_ready), 64'd1);

    // Reset during SHIFT bit 20 (period 22, offset 89 from the first UIR cycle).
    run_cmd(2'b11, 38'h15_1234_5678, -1, 90, lat, rises);
    chk("rst_tck", 64'(vji_tck), 64'd0);
    chk("rst_tdi", 64'(vji_tdi), 64'd0);
    chk("rst_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti}), 64'd0);
    chk("rst_ir_in", 64'(vji_ir_in), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_ir_out, rsp_data}), 64'd0);
    reset = 1'b0;
    #1;
    chk("rst_release_ready", 64'(cmd_ready), 64'd1);
    vji_ir_out = 2'b01;
    run_cmd(2'b10, 38'h3C_0F0F_A5A5, -1, -1, lat, rises);
    chk("post_reset_latency", 64'(lat), 64'(LAT_MAIN));
    chk("post_reset_data", 64'(rsp_data), 64'h38_1E1F_4B4A);
    chk("post_reset_ir_out", 64'(rsp_ir_out), 64'h1);
    rsp_ready = 1'b1;
    tick();

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 6000; i++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_ir     = 2'($urandom);
      cmd_data   = SR'({$urandom(), $urandom()});
      rsp_ready  = ($urandom_range(0, 1) == 1);
      vji_ir_out = 2'($urandom);
      reset      = ($urandom_range(0, 799) == 0);
      tick();
    end
    cmd_valid = 1'b0; reset = 1'b0; rsp_ready = 1'b1;
    tick(); tick();

    // Small build: TCK toggles every clk, TDO constant 1.
    s_cmd_valid = 1'b1; s_cmd_ir = 2'b11;
    chk("small_ready", 64'(s_cmd_ready), 64'd1);
    lat = -1; tck_err = 0;
    begin
      int a;
      a = dcyc;
      tick();
      s_cmd_valid = 1'b0;
      for (int i = 1; i < 100; i++) begin
        if (s_rsp_valid) begin lat = dcyc - a; break; end
        if (i - 1 < ACT_SMALL && s_tck != 1'((i - 1) % 2)) tck_err++;
        tick();
      end
    end
    chk("small_latency", 64'(lat), 64'(LAT_SMALL));
    chk("small_rsp_data", 64'(s_rsp_data), 64'h3);
    chk("small_tck_pattern_errors", 64'(tck_err), 64'd0);
    tick();
    chk("small_idle_after_rsp", 64'({s_rsp_valid, s_cmd_ready}), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
